// File: rtl/pipe_hazard_ctrl.sv
`timescale 1ns/1ps
// pipe_hazard_ctrl: stall/flush/bubble controller for the RV32I PC and pipeline registers.
// Optional wrapping performance counters are compiled in with `define PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES     = 4,
    parameter int FLUSH_DEPTH    = 2,
    parameter int EX_STAGE       = 2,
    parameter int LU_CYCLES      = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_mem_busy,
    input  logic                  d_mem_busy,
    input  logic                  flush,
    input  logic                  stall_FU,
    input  logic                  ex_busy,
    output logic                  we_PC,
    output logic [NUM_STAGES-1:0] we_stage,
    output logic [NUM_STAGES-1:0] nop_stage,
    output logic                  flush_pending,
    output logic                  stall_timeout
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt,
    output logic [31:0]           perf_lu_cnt
`endif
);

    localparam int LU_W  = (LU_CYCLES > 1) ? $clog2(LU_CYCLES) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [LU_W-1:0]       LU_RELOAD  = LU_W'(LU_CYCLES - 1);
    localparam logic [LU_W-1:0]       LU_ONE     = LU_W'(1);
    localparam logic [TMO_W-1:0]      TMO_MAX    = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0]      TMO_ONE    = TMO_W'(1);
    localparam logic [NUM_STAGES-1:0] ALL_ONES   = {NUM_STAGES{1'b1}};
    localparam logic [NUM_STAGES-1:0] FLUSH_MASK = ALL_ONES >> (NUM_STAGES - FLUSH_DEPTH);
    localparam logic [NUM_STAGES-1:0] EX_LO_MASK = ALL_ONES >> (NUM_STAGES - EX_STAGE);

    typedef enum logic [2:0] {
        MODE_RUN   = 3'd0,
        MODE_MEM   = 3'd1,
        MODE_FLUSH = 3'd2,
        MODE_EX    = 3'd3,
        MODE_LU    = 3'd4
    } mode_e;

    mode_e              mode_s;
    logic [LU_W-1:0]    lu_cnt_q, lu_cnt_d;
    logic               flush_pend_q, flush_pend_d;
    logic [TMO_W-1:0]   frz_cnt_q, frz_cnt_d;
    logic               timeout_q, timeout_d;

    // Priority decode of this cycle's hazard: memory > flush > EX freeze > load-use.
    always_comb begin
        mode_s = MODE_RUN;
        if (i_mem_busy || d_mem_busy) begin
            mode_s = MODE_MEM;
        end else if (flush || flush_pend_q) begin
            mode_s = MODE_FLUSH;
        end else if (ex_busy) begin
            mode_s = MODE_EX;
        end else if (stall_FU || (lu_cnt_q != {LU_W{1'b0}})) begin
            mode_s = MODE_LU;
        end else begin
            mode_s = MODE_RUN;
        end
    end

    // Pipeline control outputs plus load-use hold and deferred-flush next state.
    always_comb begin
        we_PC        = 1'b1;
        we_stage     = ALL_ONES;
        nop_stage    = {NUM_STAGES{1'b0}};
        lu_cnt_d     = lu_cnt_q;
        flush_pend_d = 1'b0;
        case (mode_s)
            MODE_MEM: begin
                we_PC        = 1'b0;
                we_stage     = {NUM_STAGES{1'b0}};
                flush_pend_d = flush_pend_q | flush;
            end
            MODE_FLUSH: begin
                nop_stage = FLUSH_MASK;
                lu_cnt_d  = {LU_W{1'b0}};
            end
            MODE_EX: begin
                we_PC               = 1'b0;
                we_stage            = ~EX_LO_MASK;
                nop_stage[EX_STAGE] = 1'b1;
            end
            MODE_LU: begin
                we_PC        = 1'b0;
                we_stage[0]  = 1'b0;
                nop_stage[1] = 1'b1;
                if (lu_cnt_q != {LU_W{1'b0}}) begin
                    lu_cnt_d = lu_cnt_q - LU_ONE;
                end else begin
                    lu_cnt_d = LU_RELOAD;
                end
            end
            default: begin
                lu_cnt_d = lu_cnt_q;
            end
        endcase
    end

    // Watchdog: count consecutive PC-frozen cycles, saturate, and latch a sticky flag.
    always_comb begin
        if (we_PC) begin
            frz_cnt_d = {TMO_W{1'b0}};
        end else if (frz_cnt_q == TMO_MAX) begin
            frz_cnt_d = frz_cnt_q;
        end else begin
            frz_cnt_d = frz_cnt_q + TMO_ONE;
        end
        timeout_d = timeout_q | (frz_cnt_d == TMO_MAX);
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lu_cnt_q     <= {LU_W{1'b0}};
            flush_pend_q <= 1'b0;
            frz_cnt_q    <= {TMO_W{1'b0}};
            timeout_q    <= 1'b0;
        end else begin
            lu_cnt_q     <= lu_cnt_d;
            flush_pend_q <= flush_pend_d;
            frz_cnt_q    <= frz_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign flush_pending = flush_pend_q;
    assign stall_timeout = timeout_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q, perf_lu_q;
    logic        lu_entry_s;

    assign lu_entry_s = (mode_s == MODE_LU) && (lu_cnt_q == {LU_W{1'b0}});

    // Wrapping event counters for stalls, flush cycles and load-use entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
            perf_lu_q    <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_q + {31'd0, ~we_PC};
            perf_flush_q <= perf_flush_q + {31'd0, (mode_s == MODE_FLUSH)};
            perf_lu_q    <= perf_lu_q + {31'd0, lu_entry_s};
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
    assign perf_lu_cnt    = perf_lu_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
// Bench for pipe_hazard_ctrl: three instances (LU_CYCLES 1/3/4, TIMEOUT_CYCLES 8) share one
// stimulus stream and are compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int NS  = 4;
    localparam int FD  = 2;
    localparam int EXS = 2;
    localparam int TMO = 8;
    localparam logic [10:0] RUN_VEC = 11'b1_1111_0000_0_0;

    logic clk = 1'b0;
    logic rst;
    logic i_mem_busy, d_mem_busy, flush, stall_FU, ex_busy;

    logic          we_pc  [3];
    logic [NS-1:0] we_st  [3];
    logic [NS-1:0] nop_st [3];
    logic          fp_o   [3];
    logic          tmo_o  [3];

    int checks = 0;
    int errors = 0;

    // model state: extra hold cycles still owed, deferred flush, frozen-cycle run, sticky flag
    int lu_cfg    [3] = '{1, 3, 4};
    int hold_left [3];
    bit pend_m    [3];
    int frz_m     [3];
    bit tmo_m     [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pipe_hazard_ctrl #(
            .NUM_STAGES    (NS),
            .FLUSH_DEPTH   (FD),
            .EX_STAGE      (EXS),
            .LU_CYCLES     ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
            .TIMEOUT_CYCLES(TMO)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .i_mem_busy   (i_mem_busy),
            .d_mem_busy   (d_mem_busy),
            .flush        (flush),
            .stall_FU     (stall_FU),
            .ex_busy      (ex_busy),
            .we_PC        (we_pc[g]),
            .we_stage     (we_st[g]),
            .nop_stage    (nop_st[g]),
            .flush_pending(fp_o[g]),
            .stall_timeout(tmo_o[g])
        );
    end

    // 0 run, 1 memory freeze, 2 flush, 3 EX freeze, 4 load-use
    function automatic int mode_of(int k);
        if (i_mem_busy || d_mem_busy) return 1;
        if (flush || pend_m[k])       return 2;
        if (ex_busy)                  return 3;
        if (stall_FU || hold_left[k] > 0) return 4;
        return 0;
    endfunction

    function automatic logic [10:0] exp_vec(int k);
        logic          pc;
        logic [NS-1:0] we, nop;
        case (mode_of(k))
            1:       begin pc = 1'b0; we = 4'b0000; nop = 4'b0000; end
            2:       begin pc = 1'b1; we = 4'b1111; nop = 4'((1 << FD) - 1); end
            3:       begin pc = 1'b0; we = 4'(15 - ((1 << EXS) - 1)); nop = 4'(1 << EXS); end
            4:       begin pc = 1'b0; we = 4'b1110; nop = 4'b0010; end
            default: begin pc = 1'b1; we = 4'b1111; nop = 4'b0000; end
        endcase
        return {pc, we, nop, pend_m[k], tmo_m[k]};
    endfunction

    function automatic logic [10:0] obs_vec(int k);
        return {we_pc[k], we_st[k], nop_st[k], fp_o[k], tmo_o[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            hold_left[k] = 0; pend_m[k] = 1'b0; frz_m[k] = 0; tmo_m[k] = 1'b0;
        end
    endtask

    // wait for the active edge, move the model one cycle, then step off the edge
    task automatic advance();
        int m;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 3; k++) begin
                m = mode_of(k);
                pend_m[k] = (m == 1) ? (pend_m[k] | flush) : 1'b0;
                if (m == 2) hold_left[k] = 0;
                else if (m == 4) hold_left[k] = (hold_left[k] > 0) ? hold_left[k] - 1 : lu_cfg[k] - 1;
                if (m == 0 || m == 2) frz_m[k] = 0;
                else frz_m[k] = (frz_m[k] + 1 > TMO) ? TMO : frz_m[k] + 1;
                if (frz_m[k] >= TMO) tmo_m[k] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic drive(input logic im, input logic dm, input logic fl, input logic sf, input logic ex);
        i_mem_busy = im; d_mem_busy = dm; flush = fl; stall_FU = sf; ex_busy = ex;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) advance();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #2;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs_vec(k) !== RUN_VEC) begin
                errors++;
                $display("FAIL reset dut%0d got %b exp %b", k, obs_vec(k), RUN_VEC);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
                errors++;
                $display("FAIL reset_release dut%0d got %b exp %b", k, obs_vec(k), exp_vec(k));
            end
        end
        advance();
    endtask

    task automatic test_load_use();
        logic [8:0] want;
        idle(2);
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b0, 1'b0, (c < 2), 1'b0);
            @(negedge clk);
            want = (c < 2) ? 9'b0_1110_0010 : 9'b1_1111_0000;
            checks++;
            if (obs_vec(0)[10:2] !== want) begin
                errors++;
                $display("FAIL load_use_lu1 cyc%0d got %b exp %b", c, obs_vec(0)[10:2], want);
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL load_use cyc%0d dut%0d got %b exp %b", c, k, obs_vec(k), exp_vec(k));
                end
            end
            advance();
        end
    endtask

    task automatic test_lu_hold_flush();
        logic [8:0] want;
        idle(4);
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 1'b0, (c == 6), (c == 0 || c == 5), 1'b0);
            @(negedge clk);
            if (c == 6)                               want = 9'b1_1111_0011;
            else if (c == 0 || c == 1 || c == 2 || c == 5) want = 9'b0_1110_0010;
            else                                      want = 9'b1_1111_0000;
            checks++;
            if (obs_vec(1)[10:2] !== want) begin
                errors++;
                $display("FAIL lu_hold_flush_lu3 cyc%0d got %b exp %b", c, obs_vec(1)[10:2], want);
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL lu_hold_flush cyc%0d dut%0d got %b exp %b", c, k, obs_vec(k), exp_vec(k));
                end
            end
            advance();
        end
    endtask

    task automatic test_deferred_flush();
        logic [10:0] want [5] = '{11'b0_0000_0000_0_0, 11'b0_0000_0000_1_0, 11'b0_0000_0000_1_0,
                                  11'b1_1111_0011_1_0, 11'b1_1111_0000_0_0};
        idle(4);
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, (c < 3), (c == 0), 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (obs_vec(0) !== want[c]) begin
                errors++;
                $display("FAIL deferred_flush cyc%0d got %b exp %b", c, obs_vec(0), want[c]);
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL deferred_flush_model cyc%0d dut%0d got %b exp %b", c, k, obs_vec(k), exp_vec(k));
                end
            end
            advance();
        end
    endtask

    task automatic test_ex_busy();
        logic [8:0] want;
        idle(2);
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b0, 1'b0, (c < 4), (c < 4));
            @(negedge clk);
            want = (c < 4) ? 9'b0_1100_0100 : 9'b1_1111_0000;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_vec(k)[10:2] !== want) begin
                    errors++;
                    $display("FAIL ex_busy cyc%0d dut%0d got %b exp %b", c, k, obs_vec(k)[10:2], want);
                end
            end
            advance();
        end
    endtask

    task automatic test_timeout();
        idle(2);
        for (int c = 0; c < 14; c++) begin
            drive((c < 10), 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (tmo_o[0] !== (c >= 8)) begin
                errors++;
                $display("FAIL timeout cyc%0d got %b exp %b", c, tmo_o[0], (c >= 8));
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL timeout_model cyc%0d dut%0d got %b exp %b", c, k, obs_vec(k), exp_vec(k));
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        advance();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (obs_vec(2) !== exp_vec(2)) begin
            errors++;
            $display("FAIL mid_stall_hold got %b exp %b", obs_vec(2), exp_vec(2));
        end
        advance();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs_vec(k) !== RUN_VEC) begin
                errors++;
                $display("FAIL mid_stall_reset dut%0d got %b exp %b", k, obs_vec(k), RUN_VEC);
            end
        end
        advance();
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_vec(k) !== RUN_VEC) begin
                    errors++;
                    $display("FAIL post_reset cyc%0d dut%0d got %b exp %b", c, k, obs_vec(k), RUN_VEC);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 8),
                  ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 30),
                  ($urandom_range(0, 99) < 15));
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL random cyc%0d dut%0d got %b exp %b", c, k, obs_vec(k), exp_vec(k));
                end
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_lu_hold_flush();
        test_deferred_flush();
        test_ex_busy();
        test_timeout();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
